// File: rtl/flog_pack.sv
// bfloat16 log2 output stage: merges the unbiased exponent with log2(1.M),
// normalizes the fixed-point sum one bit per cycle, rounds RNE and packs the result.
module flog_pack #(
    parameter int FRAC_W = 16,
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int BIAS   = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [FRAC_W-1:0]      frac_in,
    input  logic                   is_zero,
    input  logic                   is_inf,
    input  logic                   is_nan,
    input  logic                   is_neg,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   out_valid
);

    localparam int W = FRAC_W + 8;
    // Exponent of a magnitude whose leading one already sits at bit W-1.
    localparam logic [EXP_W-1:0] E_INIT = EXP_W'(BIAS + W - 1 - FRAC_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [W-1:0]     mag;
    logic [EXP_W-1:0] e_acc;
    logic             sign;

    logic             sign_ld;
    logic [EXP_W-1:0] exp_diff;
    logic [W-1:0]     mag_ld;

    function automatic logic [EXP_W+MAN_W-1:0] round_rne(
        input logic [W-1:0]     m_in,
        input logic [EXP_W-1:0] e_in
    );
        logic [MAN_W-1:0] m;
        logic [EXP_W-1:0] e;
        logic             g;
        logic             s;
        m = m_in[W-2 -: MAN_W];
        g = m_in[W-2-MAN_W];
        s = |m_in[W-3-MAN_W:0];
        e = e_in;
        if (g && (s || m[0])) begin
            if (&m) begin
                m = '0;
                e = e + EXP_W'(1);
            end else begin
                m = m + MAN_W'(1);
            end
        end
        return {e, m};
    endfunction

    // Signed y is carried as sign + magnitude so normalization only ever shifts left.
    always_comb begin
        sign_ld  = (exp_in < EXP_W'(BIAS));
        exp_diff = sign_ld ? (EXP_W'(BIAS) - exp_in) : (exp_in - EXP_W'(BIAS));
        mag_ld   = sign_ld ? ((W'(exp_diff) << FRAC_W) - W'(frac_in))
                           : ((W'(exp_diff) << FRAC_W) + W'(frac_in));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mag    <= '0;
            e_acc  <= '0;
            sign   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_nan || is_neg) begin
                            result <= 16'h7FC0;
                            state  <= DONE;
                        end else if (is_zero) begin
                            result <= 16'hFF80;
                            state  <= DONE;
                        end else if (is_inf) begin
                            result <= 16'h7F80;
                            state  <= DONE;
                        end else if (mag_ld == '0) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            mag   <= mag_ld;
                            sign  <= sign_ld;
                            e_acc <= E_INIT;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[W-1]) begin
                        state <= ROUND;
                    end else begin
                        mag   <= mag << 1;
                        e_acc <= e_acc - EXP_W'(1);
                    end
                end
                ROUND: begin
                    result <= {sign, round_rne(mag, e_acc)};
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
